// File: rtl/ladybird_fetch_if.sv
// ladybird_fetch_if: ladybird_bus word-access bus between a primary and the RAM secondary
//   req/addr/wstrb : primary -> secondary request; accepted when req && gnt
//   gnt            : secondary accepts the request this cycle
//   data/data_gnt  : read data returned in order, valid while data_gnt is high
interface ladybird_bus;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] data;
  logic        gnt;
  logic        data_gnt;
  modport primary (output req, addr, wstrb, input data, gnt, data_gnt);
  modport secondary (input req, addr, wstrb, output data, gnt, data_gnt);
endinterface

// File: rtl/ladybird_fetch.sv
// ladybird_fetch: sequential instruction fetch with credit-limited bus reads, PC-tagged FIFO and redirect flush
//   clk, anrst                  : clock, asynchronous active-low reset
//   bus                         : ladybird_bus primary (read-only)
//   fetch_en                    : enables issue; low only pauses requests
//   redirect_valid, redirect_pc : flush everything and restart at the word-aligned redirect_pc
//   inst_valid/ready/data/pc    : registered FIFO head towards decode
module ladybird_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic         clk,
  input  logic         anrst,
  ladybird_bus.primary bus,
  input  logic         fetch_en,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [31:0]  inst_data,
  output logic [31:0]  inst_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, nxt_rd;
  logic [AW:0]   count, nxt_count;
  logic [31:0]   pcq [MAX_OUTSTANDING];
  logic [QW-1:0] q_rd, q_wr;
  logic [OW-1:0] outstanding, discard;
  logic          accept, live, pop;
  function automatic logic [QW-1:0] qnext(input logic [QW-1:0] p);
    return p == QW'(MAX_OUTSTANDING - 1) ? '0 : p + QW'(1);
  endfunction
  // Credit counts words already buffered plus every read still on the bus (kept or to be dropped),
  // so a response always finds a free FIFO slot.
  assign bus.req = state == RUN && fetch_en && !redirect_valid &&
                   32'(count) + 32'(outstanding) + 32'(discard) < DEPTH &&
                   32'(outstanding) + 32'(discard) < MAX_OUTSTANDING;
  assign bus.addr  = pc;
  assign bus.wstrb = '0;
  assign accept    = bus.req && bus.gnt;
  // Responses are in order, so stale (pre-redirect) words always arrive before any kept one.
  assign live      = bus.data_gnt && discard == '0 && outstanding != '0;
  assign pop       = inst_valid && inst_ready;
  assign nxt_rd    = rd_ptr + AW'(pop);
  assign nxt_count = count + (AW+1)'(live) - (AW+1)'(pop);
  always_ff @(posedge clk) begin
    if (live && !redirect_valid) begin
      fifo_data[wr_ptr] <= bus.data;
      fifo_pc[wr_ptr]   <= pcq[q_rd];
    end
    if (accept) pcq[q_wr] <= pc;
  end
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      outstanding <= '0;
      discard     <= '0;
      inst_valid  <= 1'b0;
      inst_data   <= '0;
      inst_pc     <= '0;
    end else if (redirect_valid) begin
      state       <= (state == RUN || fetch_en) ? RUN : IDLE;
      pc          <= redirect_pc & ~32'd3;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inst_valid  <= 1'b0;
      q_rd        <= '0;
      q_wr        <= '0;
      outstanding <= '0;
      // Everything still in flight becomes stale; a response arriving now is already dropped.
      discard     <= discard + outstanding - OW'(bus.data_gnt && (discard != '0 || outstanding != '0));
    end else begin
      if (state == IDLE && fetch_en) state <= RUN;
      if (accept) pc <= pc + 32'd4;
      if (accept) q_wr <= qnext(q_wr);
      if (live) q_rd <= qnext(q_rd);
      outstanding <= outstanding + OW'(accept) - OW'(live);
      if (bus.data_gnt && discard != '0) discard <= discard - OW'(1);
      if (live) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= nxt_rd;
      count      <= nxt_count;
      inst_valid <= nxt_count != '0;
      // The new head is the word written this cycle when it lands straight on the read slot.
      if (nxt_count != '0) begin
        inst_data <= live && wr_ptr == nxt_rd ? bus.data : fifo_data[nxt_rd];
        inst_pc   <= live && wr_ptr == nxt_rd ? pcq[q_rd] : fifo_pc[nxt_rd];
      end
    end
  end
endmodule

// File: doc/ladybird_fetch.md
Name: ladybird_fetch

Overview:
- Instruction fetch stage. Bus primary that issues sequential word reads to the instruction RAM over ladybird_bus, buffers returned words with their PCs in a small FIFO, and presents them to decode with valid/ready.
- Supports a redirect (jump/branch) that flushes the FIFO and discards responses still in flight.
- Sits directly upstream of the RAM secondary port and directly ahead of decode.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, instruction FIFO entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered bus reads (>=1).

Ports:
- clk  input  1  clock; all state on rising edge.
- anrst  input  1  asynchronous active-low reset.
- bus  ladybird_bus.primary  -  req, addr[31:0], wstrb[3:0], data[31:0], gnt, data_gnt.
- fetch_en  input  1  start/continue fetching; deassert pauses issue only.
- redirect_valid  input  1  flush and restart at redirect_pc.
- redirect_pc  input  32  new fetch address, word aligned (bits[1:0] ignored, treated as 0).
- inst_valid  output  1  FIFO head valid.
- inst_ready  input  1  decode accepts head when inst_valid && inst_ready.
- inst_data  output  32  instruction word at head.
- inst_pc  output  32  address of inst_data.

Behaviour:
- Reset (anrst low, async): pc=RESET_PC, state=IDLE, FIFO empty, outstanding=0, discard=0. Outputs inst_valid=0, inst_data=0, inst_pc=0, bus.req=0, bus.addr=RESET_PC, bus.wstrb=0. Reset mid-transaction drops everything; a late data_gnt after reset release is not expected.
- Bus rules:
  - Fetch never writes: wstrb is held at 4'b0000 and the fetch never drives bus.data.
  - A request is accepted when req && gnt in the same cycle.
  - Read data returns in order, on bus.data with data_gnt, at least 1 cycle after acceptance.
  - req and addr stay stable until accepted.
- States:
  - IDLE: req=0. Goes to RUN the cycle after fetch_en=1.
  - RUN: req = fetch_en && !redirect_valid && (count + outstanding + discard) < DEPTH && (outstanding + discard) < MAX_OUTSTANDING. addr=pc. On accept, pc <= pc+4 (32-bit wrap, FFFF_FFFC -> 0000_0000). fetch_en=0 while in RUN only masks req; state stays RUN.
- Outstanding counter: +1 on accept, -1 on data_gnt, net 0 when both occur in the same cycle.
- Response path on data_gnt:
  - If discard>0: drop the word, discard -1.
  - Otherwise: write {data, pc_of_request} into the FIFO. The request PC comes from an internal PC queue of MAX_OUTSTANDING entries pushed on accept.
  - The credit check guarantees the FIFO never overflows.
- FIFO: registered outputs. A word written in cycle N is visible on inst_valid no earlier than cycle N+1. Push and pop in the same cycle are allowed, including when full. Empty -> inst_valid=0 and inst_data/inst_pc hold their last values.
- Redirect (priority over everything in that cycle):
  - No request is issued.
  - FIFO is cleared; a pop in the same cycle is ignored.
  - discard <= outstanding - (data_gnt ? 1 : 0); the response arriving that cycle is dropped.
  - outstanding <= 0; PC queue is cleared.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - From IDLE, a redirect also moves the state to RUN if fetch_en=1.
  - A redirect while discard>0 adds the new in-flight count to discard.
  - Issue resumes the next cycle, subject to credit.
- Latency with a 1-cycle RAM (gnt=1, data_gnt one cycle after req):
  - fetch_en at cycle 0, req at cycle 1, data_gnt at cycle 2, inst_valid at cycle 3.
  - Sustained 1 instruction/cycle when inst_ready=1 and DEPTH>=3.

Test Plan:
- Basic stream: reset, fetch_en=1, inst_ready=1, RAM preloaded with words 0..4 -> addr sequence 0,4,8,...; inst_valid first at cycle 3; inst_pc 0,4,8,C,10 back-to-back with the matching inst_data.
- Backpressure: inst_ready=0 for 10 cycles -> req drops once count+outstanding reaches 4, FIFO holds PCs 0..C with no loss; release -> in-order drain and req resumes the following cycle.
- Redirect with traffic in flight: redirect_valid with redirect_pc=32'h40, asserted in the cycle data_gnt returns the word for pc 8 -> that word and any later stale response are dropped, inst_valid low the next cycle, next issued addr=32'h40, first delivered inst_pc=32'h40.
- Misaligned redirect and wrap: redirect_pc=32'hFFFF_FFFE -> addr FFFF_FFFC, then 0000_0000.
- Slow secondary: gnt low 3 cycles, data_gnt 2 cycles after accept -> req/addr held stable while gnt is low, outstanding never exceeds 2, delivered order preserved.
- Async reset mid-stream: anrst pulsed low between clock edges -> inst_valid=0 and req=0 immediately; after release, fetching restarts at RESET_PC once fetch_en=1.
